z80_io_lcd_bridge: RTL
======================

// Module: z80_io_lcd_bridge
// PURPOSE
//  Clocked Z80 I/O port block: synchronises the Z80 I/O strobes into the in_clock domain and decodes NREG byte registers.
//  Generates HD44780 (LCD1602) write cycles with programmable setup, E-pulse and hold timing, so a single OUT no longer
//  needs software-stretched strobes. Provides a readable status port (busy/overrun) and the keyboard read enable.
//  Sits in the CPLD between the Z80 bus pins and the LED/LCD/keyboard pins.
// PARAMETERS
//  ADDR_W     3   number of low address bits decoded (adr width)
//  NREG       2   number of 8-bit output registers, at addresses REG_BASE..REG_BASE+NREG-1
//  REG_BASE   6   address of reg[0]; reg[0] bit0=led, bit1=lcd_rw, bit2=lcd_rs
//  LCD_ADDR   5   OUT: LCD data write; IN: status byte
//  KBD_ADDR   6   IN: keyboard read (kbd_n low)
//  SYNC_ST    2   synchroniser stages on iorq/rd/wr (>=2)
//  SETUP_CYC  2   in_clock cycles RS/RW/D valid before E rises (>=1)
//  E_CYC      12  in_clock cycles E high (>=1)
//  HOLD_CYC   2   in_clock cycles D held after E falls (>=1)
// PORTS
//  in_clock   in   1        single clock; all state on rising edge
//  rst        in   1        asynchronous, active-low reset
//  adr        in   ADDR_W   Z80 low address bits
//  iorq       in   1        Z80 IORQ_n
//  rd         in   1        Z80 RD_n
//  wr         in   1        Z80 WR_n
//  busrq      in   1        1 = block enabled; 0 = bus lent out, block idle
//  data_in    in   8        Z80 data bus (input side)
//  data_out   out  8        status byte driven on IN from LCD_ADDR
//  data_oe    out  1        1 = drive data_out onto bus
//  reg_out    out  8*NREG   register contents, reg[i] at [8i+7:8i]
//  led        out  1        reg[0][0]
//  lcd_e      out  1        LCD enable
//  lcd_rs     out  1        LCD register select (latched per transfer)
//  lcd_rw     out  1        LCD read/write (latched per transfer)
//  lcd_d      out  8        LCD data (latched per transfer)
//  kbd_n      out  1        0 = keyboard read in progress, else 1
// BEHAVIOUR
//  Reset (rst=0, async): reg[*]=0, led=0, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_d=0, overrun=0, FSM=IDLE, sync chains=1 (inactive).
//  Sync: iorq/rd/wr pass SYNC_ST flops. wr_act=~iorq_s&~wr_s, rd_act=~iorq_s&~rd_s.
//  wr_evt = one-cycle pulse on 0->1 of wr_act; adr/data_in are sampled in that cycle (stable in Z80 I/O cycle).
//  rd_end = one-cycle pulse on 1->0 of rd_act.
//  Registers: wr_evt & adr==REG_BASE+i (i<NREG) -> reg[i]<=data_in next edge. Other addresses do not touch regs.
//  Read path (combinational from raw pins, no sync latency): data_oe=busrq&~iorq&~rd&(adr==LCD_ADDR);
//   data_out={busy,overrun,6'b0}. kbd_n=~(busrq&~iorq&~rd&(adr==KBD_ADDR)).
//  rd_end with adr==LCD_ADDR clears overrun; a simultaneous set wins (overrun stays 1).
//  LCD FSM states IDLE->SETUP->PULSE->HOLD->IDLE; busy=(state!=IDLE).
//   IDLE: wr_evt & adr==LCD_ADDR -> lcd_d<=data_in, lcd_rs<=reg[0][2], lcd_rw<=reg[0][1]; cnt<=SETUP_CYC-1; ->SETUP.
//   SETUP: lcd_e=0; cnt==0 -> cnt<=E_CYC-1, ->PULSE, else cnt--.
//   PULSE: lcd_e=1 (registered); cnt==0 -> cnt<=HOLD_CYC-1, ->HOLD, else cnt--.
//   HOLD: lcd_e=0, lcd_d/rs/rw held; cnt==0 -> IDLE.
//   Timing from wr_evt cycle T: lcd_e high for cycles T+1+SETUP_CYC..T+SETUP_CYC+E_CYC; busy for SETUP_CYC+E_CYC+HOLD_CYC cycles.
//   wr_evt to LCD_ADDR while busy: transfer dropped, lcd_d unchanged, overrun<=1.
//   Register write to reg[0] during a transfer does not alter latched lcd_rs/lcd_rw.
//  busrq=0: wr_evt ignored (no reg/LCD update); FSM forced to IDLE next edge, lcd_e=0 (aborted pulse truncated);
//   data_oe=0, kbd_n=1; reg contents and overrun retained.
//  rst asserted mid-transfer: lcd_e drops to 0 immediately (async), all state to reset values.
//  Counters sized $clog2(max(SETUP_CYC,E_CYC,HOLD_CYC)+1); no wrap possible as loads are <= max.
// TESTING
//  T1 reset: rst=0 during active PULSE -> lcd_e=0 same time, reg_out=0, data_out on status read = 8'h00.
//  T2 reg write: OUT (6),8'h05 -> reg_out[7:0]=8'h05, led=1 within SYNC_ST+2 cycles; OUT (7),8'hA5 -> reg_out[15:8]=8'hA5.
//  T3 LCD write: reg[0]=8'h04, OUT (5),8'h41 -> lcd_d=8'h41, lcd_rs=1, lcd_rw=0, lcd_e high exactly 12 cycles after 2 setup;
//     status read during transfer = 8'h80, after 16 cycles = 8'h00.
//  T4 overrun: second OUT (5),8'h42 while busy -> lcd_d stays 8'h41, status=8'hC0; next read after idle = 8'h00.
//  T5 keyboard/status decode: IN (6) -> kbd_n=0, data_oe=0; IN (5) -> data_oe=1, kbd_n=1; IN (3) -> both inactive.
//  T6 busrq: busrq=0 mid-PULSE -> lcd_e=0 next edge, FSM IDLE; OUT (6),8'hFF while busrq=0 -> reg_out unchanged.

Source files
------------

// File: rtl/z80_io_lcd_bridge_if.sv
// Z80 I/O bus bundle between the CPU-side pins and the I/O port bridge.
interface z80_io_lcd_bridge_if #(
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] adr;
    logic              iorq;
    logic              rd;
    logic              wr;
    logic              busrq;
    logic [7:0]        data_in;
    logic [7:0]        data_out;
    logic              data_oe;

    modport master (
        output adr, iorq, rd, wr, busrq, data_in,
        input  data_out, data_oe
    );

    modport slave (
        input  adr, iorq, rd, wr, busrq, data_in,
        output data_out, data_oe
    );
endinterface

// File: rtl/z80_io_lcd_bridge.sv
// Z80 I/O port bridge: synchronised strobes, byte output registers,
// HD44780 write-cycle sequencer with status port and keyboard read enable.
module z80_io_lcd_bridge #(
    parameter int ADDR_W    = 3,
    parameter int NREG      = 2,
    parameter int REG_BASE  = 6,
    parameter int LCD_ADDR  = 5,
    parameter int KBD_ADDR  = 6,
    parameter int SYNC_ST   = 2,
    parameter int SETUP_CYC = 2,
    parameter int E_CYC     = 12,
    parameter int HOLD_CYC  = 2
) (
    input  logic                in_clock,
    input  logic                rst,
    z80_io_lcd_bridge_if.slave  bus,
    output logic [8*NREG-1:0]   reg_out,
    output logic                led,
    output logic                lcd_e,
    output logic                lcd_rs,
    output logic                lcd_rw,
    output logic [7:0]          lcd_d,
    output logic                kbd_n
);
    localparam int MAX_SE  = (SETUP_CYC > E_CYC) ? SETUP_CYC : E_CYC;
    localparam int MAX_CYC = (MAX_SE > HOLD_CYC) ? MAX_SE : HOLD_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    logic [SYNC_ST-1:0] iorq_sync, rd_sync, wr_sync;
    logic               wr_act, rd_act, wr_act_q, rd_act_q;
    logic               wr_evt, rd_end, wr_evt_en;
    logic               rd_pin, lcd_sel, kbd_sel;
    logic [7:0]         regs [NREG];
    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               load, ovr_set, ovr_clr, overrun, busy;

    assign wr_act    = ~iorq_sync[SYNC_ST-1] & ~wr_sync[SYNC_ST-1];
    assign rd_act    = ~iorq_sync[SYNC_ST-1] & ~rd_sync[SYNC_ST-1];
    assign wr_evt    = wr_act & ~wr_act_q;
    assign rd_end    = ~rd_act & rd_act_q;
    assign wr_evt_en = wr_evt & bus.busrq;

    assign lcd_sel = (bus.adr == ADDR_W'(LCD_ADDR));
    assign kbd_sel = (bus.adr == ADDR_W'(KBD_ADDR));
    assign rd_pin  = bus.busrq & ~bus.iorq & ~bus.rd;

    assign busy         = (state != IDLE);
    assign bus.data_oe  = rd_pin & lcd_sel;
    assign bus.data_out = {busy, overrun, 6'b0};
    assign kbd_n        = ~(rd_pin & kbd_sel);
    assign led          = regs[0][0];
    assign ovr_clr      = rd_end & bus.busrq & lcd_sel;

    // Strobe synchronisers and edge-detect history (idle level is high).
    always_ff @(posedge in_clock or negedge rst) begin
        if (!rst) begin
            iorq_sync <= '1;
            rd_sync   <= '1;
            wr_sync   <= '1;
            wr_act_q  <= 1'b0;
            rd_act_q  <= 1'b0;
        end else begin
            iorq_sync <= {iorq_sync[SYNC_ST-2:0], bus.iorq};
            rd_sync   <= {rd_sync[SYNC_ST-2:0], bus.rd};
            wr_sync   <= {wr_sync[SYNC_ST-2:0], bus.wr};
            wr_act_q  <= wr_act;
            rd_act_q  <= rd_act;
        end
    end

    // Output byte registers, written on a decoded OUT.
    always_ff @(posedge in_clock or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_evt_en) begin
            for (int unsigned i = 0; i < NREG; i++)
                if (bus.adr == ADDR_W'(REG_BASE + i)) regs[i] <= bus.data_in;
        end
    end

    // Flatten register array onto the output bus.
    always_comb begin
        reg_out = '0;
        for (int unsigned i = 0; i < NREG; i++) reg_out[8*i +: 8] = regs[i];
    end

    // LCD sequencer next-state, counter reload and overrun detection.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        load    = 1'b0;
        ovr_set = 1'b0;
        case (state)
            IDLE: if (wr_evt_en && lcd_sel) begin
                load    = 1'b1;
                cnt_d   = CNT_W'(SETUP_CYC - 1);
                state_d = SETUP;
            end
            SETUP: if (cnt == '0) begin
                cnt_d   = CNT_W'(E_CYC - 1);
                state_d = PULSE;
            end else cnt_d = cnt - CNT_W'(1);
            PULSE: if (cnt == '0) begin
                cnt_d   = CNT_W'(HOLD_CYC - 1);
                state_d = HOLD;
            end else cnt_d = cnt - CNT_W'(1);
            HOLD: if (cnt == '0) state_d = IDLE;
                  else cnt_d = cnt - CNT_W'(1);
            default: state_d = IDLE;
        endcase
        if (state != IDLE && wr_evt_en && lcd_sel) ovr_set = 1'b1;
        if (!bus.busrq) begin
            state_d = IDLE;
            load    = 1'b0;
        end
    end

    // LCD sequencer state, registered E, latched transfer fields, overrun flag.
    always_ff @(posedge in_clock or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            lcd_e   <= 1'b0;
            lcd_d   <= '0;
            lcd_rs  <= 1'b0;
            lcd_rw  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            lcd_e <= (state_d == PULSE);
            if (load) begin
                lcd_d  <= bus.data_in;
                lcd_rs <= regs[0][2];
                lcd_rw <= regs[0][1];
            end
            // a set in the same cycle as a clearing read wins
            if (ovr_set)      overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;
        end
    end
endmodule
